// File: rtl/axi_sram_slave_if.sv
// -----------------------------------------------------------------------------
// axi_sram_slave_if
//   AXI4 channel bundle between the CPU-side master and the SRAM slave.
//   Carries the AR/R read channels and the AW/W/B write channels; no clock or
//   reset lives here, they stay plain ports on the modules using the bundle.
//
//   AR : arid[3:0] araddr[31:0] arlen[7:0] arvalid   -> slave, arready <- slave
//   R  : rid[3:0] rdata[63:0] rresp[1:0] rlast rvalid <- slave, rready -> slave
//   AW : awid[3:0] awaddr[31:0] awlen[7:0] awvalid   -> slave, awready <- slave
//   W  : wdata[63:0] wstrb[7:0] wlast wvalid         -> slave, wready  <- slave
//   B  : bid[3:0] bresp[1:0] bvalid                  <- slave, bready  -> slave
// -----------------------------------------------------------------------------
interface axi_sram_slave_if;
  // read address
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  // read data
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // write address
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  // write data
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//   AXI4 slave main memory: a 64-bit wide SRAM array behind one outstanding
//   transaction at a time, INCR bursts of 8-byte beats only.
//
//   Parameters
//     BASE_ADDR   byte address of word 0
//     DEPTH_LOG2  log2 of the number of 64-bit words
//     RD_LAT      idle cycles between AR handshake and the first R beat (0..15)
//
//   Ports
//     aclk     clock, all logic on the rising edge
//     aresetn  asynchronous active-low reset (array contents are kept)
//     bus      axi_sram_slave_if.slave: AR/R/AW/W/B channels
//
//   Handshake arbitration in IDLE
//     awready is offered by default. When an AR is seen without a competing AW,
//     the slave commits to the read on the next cycle: arready rises and
//     awready drops. The two readies are therefore never high together, so an
//     AR and an AW arriving in the same cycle always resolve to the write, and
//     the AR simply stays pending until the write response completes. Every
//     ready/valid output is a flop, so no input reaches them combinationally.
//
//   Range check
//     A start address outside [BASE_ADDR, BASE_ADDR + 8*2^DEPTH_LOG2) makes the
//     whole burst DECERR: reads return zero data, writes are absorbed without
//     touching the array. In-range bursts wrap at the top of the array.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          RD_LAT     = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_sram_slave_if.slave   bus
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 3;   // array size in bytes

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [63:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e                state_q,   state_d;
  logic [DEPTH_LOG2-1:0] idx_q,     idx_d;
  logic [7:0]            cnt_q,     cnt_d;
  logic [3:0]            wcnt_q,    wcnt_d;
  logic                  err_q,     err_d;      // burst is DECERR
  logic                  slverr_q,  slverr_d;   // a wlast mismatch was seen
  logic [3:0]            rid_q,     rid_d;
  logic [3:0]            bid_q,     bid_d;
  logic                  arready_q, arready_d;
  logic                  awready_q, awready_d;
  logic                  rvalid_q,  rvalid_d;
  logic [63:0]           rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic                  rlast_q,   rlast_d;
  logic                  wready_q,  wready_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic                  mem_we;

  // ---------------------------------------------------------------------------
  // Address decode. An address below BASE_ADDR wraps to a huge offset, so the
  // single unsigned compare covers both ends of the window.
  // ---------------------------------------------------------------------------
  logic [31:0]           ar_off, aw_off;
  logic                  ar_in_range, aw_in_range;
  logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;

  assign ar_off      = bus.araddr - BASE_ADDR;
  assign aw_off      = bus.awaddr - BASE_ADDR;
  assign ar_in_range = {1'b0, ar_off} < SPAN;
  assign aw_in_range = {1'b0, aw_off} < SPAN;
  assign ar_idx      = ar_off[DEPTH_LOG2+2:3];
  assign aw_idx      = aw_off[DEPTH_LOG2+2:3];

  // Word that will be presented as rdata after this edge: the first word when
  // a read starts (or leaves RD_WAIT), the following word once a beat is taken.
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [63:0]           rd_word;

  assign rd_idx  = (state_q == IDLE)    ? ar_idx :
                   (state_q == RD_DATA) ? idx_q + 1'b1 : idx_q;
  assign rd_word = mem[rd_idx];

  logic ar_commit;   // an AR is waiting with no AW competing for the slot
  logic w_mismatch;  // master's wlast disagrees with the slave's beat count

  assign ar_commit  = bus.arvalid & ~bus.awvalid;
  assign w_mismatch = bus.wlast != (cnt_q == 8'd0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first so no branch leaves one
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    slverr_d  = slverr_q;
    rid_d     = rid_q;
    bid_d     = bid_q;
    arready_d = arready_q;
    awready_d = awready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.awvalid && awready_q) begin
          bid_d     = bus.awid;
          idx_d     = aw_idx;
          cnt_d     = bus.awlen;
          err_d     = ~aw_in_range;
          slverr_d  = 1'b0;
          awready_d = 1'b0;
          arready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = WR_DATA;
        end else if (bus.arvalid && arready_q) begin
          rid_d     = bus.arid;
          idx_d     = ar_idx;
          cnt_d     = bus.arlen;
          err_d     = ~ar_in_range;
          awready_d = 1'b0;
          arready_d = 1'b0;
          if (RD_LAT == 0) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_in_range ? rd_word : 64'd0;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_DECERR;
            rlast_d  = (bus.arlen == 8'd0);
            state_d  = RD_DATA;
          end else begin
            wcnt_d  = 4'(RD_LAT - 1);
            state_d = RD_WAIT;
          end
        end else begin
          arready_d = ar_commit;
          awready_d = ~ar_commit;
        end
      end

      RD_WAIT: begin
        if (wcnt_q == 4'd0) begin
          rvalid_d = 1'b1;
          rdata_d  = err_q ? 64'd0 : rd_word;
          rresp_d  = err_q ? RESP_DECERR : RESP_OKAY;
          rlast_d  = (cnt_q == 8'd0);
          state_d  = RD_DATA;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      RD_DATA: begin
        if (rvalid_q && bus.rready) begin
          if (cnt_q == 8'd0) begin
            rvalid_d  = 1'b0;
            rdata_d   = 64'd0;
            rresp_d   = RESP_OKAY;
            rlast_d   = 1'b0;
            arready_d = ar_commit;
            awready_d = ~ar_commit;
            state_d   = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = cnt_q - 8'd1;
            rdata_d = err_q ? 64'd0 : rd_word;
            rlast_d = (cnt_q == 8'd1);
          end
        end
      end

      WR_DATA: begin
        if (bus.wvalid && wready_q) begin
          mem_we = ~err_q;
          if (w_mismatch) slverr_d = 1'b1;
          if (cnt_q == 8'd0) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = err_q                    ? RESP_DECERR :
                       (slverr_q || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
            state_d  = WR_RESP;
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      WR_RESP: begin
        if (bus.bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          arready_d = ar_commit;
          awready_d = ~ar_commit;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of the others, matching real hardware.
    if (!aresetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      slverr_q  <= 1'b0;
      rid_q     <= '0;
      bid_q     <= '0;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      slverr_q  <= slverr_d;
      rid_q     <= rid_d;
      bid_q     <= bid_d;
      arready_q <= arready_d;
      awready_q <= awready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // NOTE: the array has no reset; its contents must survive aresetn, and a
  // reset port would stop it mapping onto SRAM.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.wstrb[b]) mem[idx_q][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.arready = arready_q;
  assign bus.awready = awready_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.wready  = wready_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//   Drives axi_sram_slave (256-word array, RD_LAT = 1) through directed and
//   random AXI bursts and compares every response with a word-array model of
//   the memory built from the address/strobe/range rules.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DL2   = 8;
  localparam int          WORDS = 1 << DL2;
  localparam int          LAT   = 1;
  localparam int          TMO   = 200;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_sram_slave_if bus();

  axi_sram_slave #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (DL2),
    .RD_LAT     (LAT)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [WORDS];
  logic [63:0] wq_data [$];
  logic [7:0]  wq_strb [$];

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(WORDS * 8));
  endfunction

  function automatic int word_of(input logic [31:0] a, input int k);
    return int'((((a - BASE) >> 3) + 32'(k)) % 32'(WORDS));
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [7:0] len);
    if (in_range(addr)) begin
      for (int k = 0; k <= int'(len); k++) begin
        for (int b = 0; b < 8; b++) begin
          if (wq_strb[k][b]) ref_mem[word_of(addr, k)][8*b +: 8] = wq_data[k][8*b +: 8];
        end
      end
    end
  endtask

  // ---------------- bus tasks ----------------
  logic [63:0] rq_data [$];
  logic [1:0]  rq_resp [$];
  logic        rq_last [$];
  int          r_lat;
  int          r_unstable;
  logic [3:0]  r_id;

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input int bad, output logic [1:0] resp, output logic [3:0] idv);
    int n;
    resp = 2'bxx;
    idv  = 4'bxxxx;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < TMO) begin tick(); n++; end
    if (n >= TMO) begin check("aw_timeout", 0, 1); bus.awvalid = 1'b0; return; end
    tick();
    bus.awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      bus.wdata  = wq_data[k];
      bus.wstrb  = wq_strb[k];
      bus.wlast  = (k == int'(len)) ^ (k == bad);
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < TMO) begin tick(); n++; end
      if (n >= TMO) begin check("w_timeout", 0, 1); bus.wvalid = 1'b0; return; end
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < TMO) begin tick(); n++; end
    if (n >= TMO) check("b_timeout", 0, 1);
    else begin resp = bus.bresp; idv = bus.bid; end
    tick();
    bus.bready = 1'b0;
  endtask

  // mode: 0 rready always high, 1 toggle 1/0 each cycle, 2 random
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input int mode);
    int n, c;
    logic held_v, hl, rr;
    logic [63:0] hd;
    logic [1:0]  hr;
    rq_data.delete(); rq_resp.delete(); rq_last.delete();
    r_unstable = 0; r_lat = -1; r_id = 4'bxxxx;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin tick(); n++; end
    if (n >= TMO) begin check("ar_timeout", 0, 1); bus.arvalid = 1'b0; return; end
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < TMO) begin tick(); n++; end
    if (n >= TMO) begin check("r_timeout", 0, 1); return; end
    r_lat = n;
    r_id  = bus.rid;
    c = 0; held_v = 1'b0; hd = '0; hr = '0; hl = 1'b0;
    while (rq_data.size() < int'(len) + 1 && c < TMO * 4) begin
      if (held_v && (bus.rvalid !== 1'b1 || bus.rdata !== hd || bus.rresp !== hr || bus.rlast !== hl))
        r_unstable++;
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      bus.rready = rr;
      held_v = 1'b0;
      if (bus.rvalid) begin
        if (rr) begin
          rq_data.push_back(bus.rdata);
          rq_resp.push_back(bus.rresp);
          rq_last.push_back(bus.rlast);
        end else begin
          held_v = 1'b1; hd = bus.rdata; hr = bus.rresp; hl = bus.rlast;
        end
      end
      tick();
      c++;
    end
    bus.rready = 1'b0;
  endtask

  // Write the burst already queued in wq_*, update the model, check B.
  task automatic wr_check(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, input int bad);
    logic [1:0] resp;
    logic [3:0] idv;
    logic [1:0] exp_resp;
    do_write(addr, len, id, bad, resp, idv);
    model_write(addr, len);
    exp_resp = !in_range(addr) ? 2'b11 : (bad >= 0) ? 2'b10 : 2'b00;
    check({tag, "_bresp"}, 64'(resp), 64'(exp_resp));
    check({tag, "_bid"}, 64'(idv), 64'(id));
  endtask

  // Read a burst and compare every beat against the model.
  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, input int mode);
    do_read(addr, len, id, mode);
    check({tag, "_beats"}, 64'(rq_data.size()), 64'(int'(len) + 1));
    check({tag, "_rid"}, 64'(r_id), 64'(id));
    check({tag, "_stable"}, 64'(r_unstable), 64'd0);
    for (int k = 0; k < rq_data.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), rq_data[k],
            in_range(addr) ? ref_mem[word_of(addr, k)] : 64'd0);
      check($sformatf("%s_resp%0d", tag, k), 64'(rq_resp[k]), in_range(addr) ? 64'd0 : 64'd3);
      check($sformatf("%s_last%0d", tag, k), 64'(rq_last[k]), 64'(k == int'(len)));
    end
  endtask

  task automatic fill_wq(input int beats, input bit rand_strb);
    wq_data.delete(); wq_strb.delete();
    for (int k = 0; k < beats; k++) begin
      wq_data.push_back({$urandom, $urandom});
      wq_strb.push_back(rand_strb ? 8'($urandom) : 8'hFF);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    int          bad;

    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_ctrl", 64'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
                           bus.rlast, bus.rresp, bus.bresp, bus.rid, bus.bid}), 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    aresetn = 1'b1;
    tick();
    check("idle_awready", 64'(bus.awready), 64'd1);
    check("idle_arready", 64'(bus.arready), 64'd0);

    // ---- initialise the whole array so the model is fully known ----
    fill_wq(WORDS, 1'b0);
    wr_check("fill", BASE, 8'(WORDS - 1), 4'h5, -1);

    // ---- 1: single write then readback, latency ----
    wq_data = '{64'h1122_3344_5566_7788}; wq_strb = '{8'hFF};
    wr_check("t1_wr", 32'h8000_0010, 8'd0, 4'hA, -1);
    do_read(32'h8000_0010, 8'd0, 4'h3, 0);
    check("t1_lat", 64'(r_lat), 64'(LAT));
    check("t1_data", rq_data.size() > 0 ? rq_data[0] : 64'hx, 64'h1122_3344_5566_7788);
    check("t1_last", rq_last.size() > 0 ? 64'(rq_last[0]) : 64'hx, 64'd1);
    check("t1_rid", 64'(r_id), 64'h3);

    // ---- 2: burst read with rready toggling ----
    rd_check("t2", BASE, 8'd3, 4'h7, 1);

    // ---- 3: partial strobe ----
    wq_data = '{64'd0}; wq_strb = '{8'hFF};
    wr_check("t3_w0", BASE + 32'h40, 8'd0, 4'h1, -1);
    wq_data = '{64'hAAAA_AAAA_AAAA_AAAA}; wq_strb = '{8'h0F};
    wr_check("t3_w1", BASE + 32'h40, 8'd0, 4'h2, -1);
    do_read(BASE + 32'h40, 8'd0, 4'h0, 0);
    check("t3_data", rq_data.size() > 0 ? rq_data[0] : 64'hx, 64'h0000_0000_AAAA_AAAA);

    // ---- 4: decode errors ----
    rd_check("t4_rd", 32'h7FFF_FFF8, 8'd1, 4'h4, 0);
    fill_wq(1, 1'b0);
    wq_data[0] = ~ref_mem[0];
    wr_check("t4_wr", 32'h9000_0000, 8'd0, 4'h6, -1);
    rd_check("t4_keep", BASE, 8'd1, 4'h4, 0);

    // ---- 5: simultaneous AR/AW, early wlast ----
    bus.arid = 4'h9; bus.araddr = BASE + 32'h100; bus.arlen = 8'd2; bus.arvalid = 1'b1;
    bus.awid = 4'hC; bus.awaddr = BASE + 32'h100; bus.awlen = 8'd2; bus.awvalid = 1'b1;
    #1;
    check("t5_awready", 64'(bus.awready), 64'd1);
    check("t5_arready", 64'(bus.arready), 64'd0);
    fill_wq(3, 1'b1);
    wr_check("t5_wr", BASE + 32'h100, 8'd2, 4'hC, 0);
    rd_check("t5_rd", BASE + 32'h100, 8'd2, 4'h9, 0);

    // ---- wrap across the top of the array ----
    fill_wq(4, 1'b1);
    wr_check("wrap_wr", BASE + 32'(8 * (WORDS - 2)), 8'd3, 4'hE, -1);
    rd_check("wrap_rd", BASE + 32'(8 * (WORDS - 2)), 8'd3, 4'hE, 2);

    // ---- 6: reset during the second read beat ----
    bus.arid = 4'h2; bus.araddr = BASE; bus.arlen = 8'd3; bus.arvalid = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.arready && n < TMO) begin tick(); n++; end
      tick();
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      n = 0;
      while (!bus.rvalid && n < TMO) begin tick(); n++; end
      tick();
    end
    check("t6_beat2_valid", 64'(bus.rvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    check("t6_rvalid_drop", 64'(bus.rvalid), 64'd0);
    bus.rready = 1'b0;
    tick();
    bus.arid = 4'h8; bus.araddr = 32'h8000_0010; bus.arlen = 8'd0; bus.arvalid = 1'b1;
    aresetn = 1'b1;
    tick();
    check("t6_arready", 64'(bus.arready), 64'd1);
    rd_check("t6_rd", 32'h8000_0010, 8'd0, 4'h8, 0);

    // ---- random traffic ----
    for (int it = 0; it < 40; it++) begin
      l = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 1) ? BASE - 32'(8 * $urandom_range(1, 32))
                                        : BASE + 32'(WORDS * 8) + 32'(8 * $urandom_range(0, 32));
      else
        a = BASE + 32'(8 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(l))) : -1;
        fill_wq(int'(l) + 1, 1'b1);
        wr_check($sformatf("rw%0d", it), a, l, 4'($urandom), bad);
      end else begin
        rd_check($sformatf("rr%0d", it), a, l, 4'($urandom), int'($urandom_range(0, 2)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
